// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding and accumulator sizing for conv_line_engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Wide enough for the largest product or cascade input, plus growth across K taps and a guard bit.
    function automatic int acc_width(input int k, input int i_x, input int i_w, input int i_psum);
        return ((i_psum > (i_x + i_w)) ? i_psum : (i_x + i_w)) + $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/conv_line_engine_if.sv
// conv_line_engine_if: weight-load, sample-stream and result signals of the line engine.
interface conv_line_engine_if #(
    parameter int I_X    = 8,
    parameter int I_W    = 8,
    parameter int I_PSUM = 16,
    parameter int O_SAT  = 16
) ();
    logic                     i_w_start;
    logic                     i_w_valid;
    logic signed [I_W-1:0]    i_w;
    logic                     i_valid;
    logic signed [I_X-1:0]    i_x;
    logic signed [I_PSUM-1:0] i_psum;
    logic                     o_valid;
    logic signed [O_SAT-1:0]  o_psum;
    logic                     o_busy;

    modport master (
        output i_w_start, i_w_valid, i_w, i_valid, i_x, i_psum,
        input  o_valid, o_psum, o_busy
    );

    modport slave (
        input  i_w_start, i_w_valid, i_w, i_valid, i_x, i_psum,
        output o_valid, o_psum, o_busy
    );
endinterface

// File: rtl/conv_sat_relu.sv
// conv_sat_relu: clamps a signed I-bit value into signed O bits (requires I >= O).
// With CONV_LINE_RELU_EN defined, negative results are additionally forced to zero.
module conv_sat_relu #(
    parameter int I = 20,
    parameter int O = 16
) (
    input  logic signed [I-1:0] din,
    output logic signed [O-1:0] dout
);
    localparam logic signed [I-1:0] MAX_I = {{(I-O+1){1'b0}}, {(O-1){1'b1}}};
    localparam logic signed [I-1:0] MIN_I = {{(I-O+1){1'b1}}, {(O-1){1'b0}}};

    logic signed [O-1:0] sat;

    always_comb begin
        sat = din[O-1:0];
        if (din > MAX_I) begin
            sat = {1'b0, {(O-1){1'b1}}};
        end else if (din < MIN_I) begin
            sat = {1'b1, {(O-1){1'b0}}};
        end
    end

`ifdef CONV_LINE_RELU_EN
    assign dout = sat[O-1] ? '0 : sat;
`else
    assign dout = sat;
`endif

endmodule

// File: rtl/conv_line_engine.sv
// conv_line_engine: K-tap systolic line convolution with cascaded partial sum and saturated output.
// Optional output ReLU is enabled by defining CONV_LINE_RELU_EN.
module conv_line_engine
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int I_X    = 8,
    parameter int I_W    = 8,
    parameter int I_PSUM = 16,
    parameter int O_SAT  = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    conv_line_engine_if.slave bus
);
    localparam int ACC_W = acc_width(K, I_X, I_W, I_PSUM);
    localparam int IDX_W = $clog2(K);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        fill;
    logic signed [I_W-1:0]   w      [K];
    logic signed [ACC_W-1:0] p      [K];
    logic signed [ACC_W-1:0] p_next [K];
    logic signed [ACC_W-1:0] x_ext;
    logic signed [O_SAT-1:0] sat_psum;
    logic                    o_valid_q;
    logic signed [O_SAT-1:0] o_psum_q;
    logic                    accept;

    // A start request always wins over a sample arriving in the same cycle.
    assign x_ext  = ACC_W'(bus.i_x);
    assign accept = (state == RUN) && bus.i_valid && !bus.i_w_start;

    for (genvar k = 0; k < K; k++) begin : g_tap
        logic signed [ACC_W-1:0] w_ext;
        logic signed [ACC_W-1:0] prev;
        logic signed [ACC_W-1:0] p_q;

        assign w_ext = ACC_W'(w[k]);
        if (k == 0) begin : g_head
            assign prev = ACC_W'(bus.i_psum);
        end else begin : g_body
            assign prev = p[k-1];
        end
        assign p_next[k] = prev + w_ext * x_ext;

        always_ff @(posedge i_clk) begin
            if (i_rst || bus.i_w_start) begin
                p_q <= '0;
            end else if (accept) begin
                p_q <= p_next[k];
            end
        end
        assign p[k] = p_q;
    end

    // Saturate the value the last stage is about to take, so the result lands with the accepting edge.
    conv_sat_relu #(
        .I (ACC_W),
        .O (O_SAT)
    ) u_sat (
        .din  (p_next[K-1]),
        .dout (sat_psum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            fill      <= '0;
            o_valid_q <= 1'b0;
            o_psum_q  <= '0;
            for (int k = 0; k < K; k++) begin
                w[k] <= '0;
            end
        end else begin
            o_valid_q <= 1'b0;
            if (bus.i_w_start) begin
                state <= LOAD;
                idx   <= '0;
                fill  <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (bus.i_w_valid) begin
                            w[idx] <= bus.i_w;
                            if (idx == LAST) begin
                                state <= RUN;
                                idx   <= '0;
                                fill  <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.i_valid) begin
                            if (fill == LAST) begin
                                o_valid_q <= 1'b1;
                                o_psum_q  <= sat_psum;
                            end else begin
                                fill <= fill + 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_psum  = o_psum_q;
    assign bus.o_busy  = (state != RUN);

endmodule

// File: tb/tb_conv_line_engine.sv
// tb_conv_line_engine: table-driven vectors plus hand sequences, checked through a result queue.
// Expected values follow CONV_LINE_RELU_EN when it is defined for the build.
module tb_conv_line_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    conv_line_engine_if #(.I_X(8), .I_W(8), .I_PSUM(16), .O_SAT(16)) bus ();

    conv_line_engine #(
        .K      (5),
        .I_X    (8),
        .I_W    (8),
        .I_PSUM (16),
        .O_SAT  (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0][7:0] w;
        int              x;
        int              psum;
        bit              bubbles;
        int              expv;
    } vec_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_q[$];
    int   last_psum   = 0;
    bit   mon_en      = 1'b0;
    vec_t tbl[10];

    function automatic int relu(input int v);
`ifdef CONV_LINE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t mk(input int w0, input int w1, input int w2, input int w3, input int w4,
                                input int x, input int psum, input bit bub, input int expv);
        vec_t v;
        v.w[0]    = 8'(w0);
        v.w[1]    = 8'(w1);
        v.w[2]    = 8'(w2);
        v.w[3]    = 8'(w3);
        v.w[4]    = 8'(w4);
        v.x       = x;
        v.psum    = psum;
        v.bubbles = bub;
        v.expv    = expv;
        return v;
    endfunction

    task automatic check_output(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Results are compared on the falling edge, away from the edge that produces them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_valid: got o_psum=%0d, expected no output", bus.o_psum);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check_output("o_psum", int'(bus.o_psum), e);
                    last_psum = e;
                end
            end else begin
                check_output("o_psum_hold", int'(bus.o_psum), last_psum);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_w_start = 1'b0;
        bus.i_w_valid = 1'b0;
        bus.i_w       = '0;
        bus.i_valid   = 1'b0;
        bus.i_x       = '0;
        bus.i_psum    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_psum = 0;
    endtask

    task automatic load_weights(input logic [4:0][7:0] w, input bit noise);
        bus.i_w_start = 1'b1;
        tick();
        bus.i_w_start = 1'b0;
        check_output("busy_load", int'(bus.o_busy), 1);
        for (int i = 0; i < 5; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w       = w[i];
            bus.i_valid   = noise;
            bus.i_x       = 8'sd50;
            tick();
        end
        idle_inputs();
        check_output("busy_run", int'(bus.o_busy), 0);
    endtask

    task automatic apply_stimulus(input int x, input int psum, input bit push, input int expv);
        bus.i_valid = 1'b1;
        bus.i_x     = 8'(x);
        bus.i_psum  = 16'(psum);
        if (push) begin
            exp_q.push_back(relu(expv));
        end
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
        check_output("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [4:0][7:0] ones;
        logic [4:0][7:0] twos;
        logic [4:0][7:0] nines;
        for (int i = 0; i < 5; i++) begin
            ones[i]  = 8'd1;
            twos[i]  = 8'd2;
            nines[i] = 8'd9;
        end

        tbl[0] = mk(1, 1, 1, 1, 1, 3, 0, 1'b0, 15);
        tbl[1] = mk(1, 2, 3, 4, 5, 1, 0, 1'b0, 15);
        tbl[2] = mk(1, 2, 3, 4, 5, 1, 0, 1'b1, 15);
        tbl[3] = mk(127, 127, 127, 127, 127, 127, 0, 1'b0, 32767);
        tbl[4] = mk(127, 127, 127, 127, 127, -128, 0, 1'b0, -32768);
        tbl[5] = mk(0, 0, 0, 0, 0, 77, 1000, 1'b0, 1000);
        tbl[6] = mk(-3, 2, 0, 5, -1, -7, -200, 1'b0, -221);
        tbl[7] = mk(127, 127, 127, 127, 127, 10, 32767, 1'b0, 32767);
        tbl[8] = mk(1, 1, 1, 1, 1, -1, -32768, 1'b1, -32768);
        tbl[9] = mk(-128, -128, -128, -128, -128, -1, 100, 1'b0, 740);

        idle_inputs();
        tick();
        do_reset();
        check_output("rst_o_valid", int'(bus.o_valid), 0);
        check_output("rst_o_psum", int'(bus.o_psum), 0);
        check_output("rst_o_busy", int'(bus.o_busy), 1);
        mon_en = 1'b1;

        // Samples offered before any weights are loaded must be ignored.
        for (int i = 0; i < 6; i++) apply_stimulus(9, 0, 1'b0, 0);
        drain();

        for (int t = 0; t < 10; t++) begin
            load_weights(tbl[t].w, 1'b0);
            for (int s = 0; s < 7; s++) begin
                apply_stimulus(tbl[t].x, tbl[t].psum, s >= 4, tbl[t].expv);
                if (tbl[t].bubbles) begin
                    bus.i_x    = 8'sd99;
                    bus.i_psum = 16'sd1234;
                    tick();
                end
            end
            drain();
        end

        // Ramp: each output is the sum of the last five samples.
        load_weights(ones, 1'b0);
        for (int s = 1; s <= 6; s++) begin
            apply_stimulus(s, 0, s >= 5, (s == 5) ? 15 : 20);
        end
        drain();

        // Start collides with a sample mid-stream; then a restarted load inside LOAD.
        load_weights(ones, 1'b0);
        for (int s = 0; s < 3; s++) apply_stimulus(1, 0, 1'b0, 0);
        bus.i_w_start = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_x       = 8'sd1;
        tick();
        idle_inputs();
        check_output("drop_o_valid", int'(bus.o_valid), 0);
        check_output("drop_o_busy", int'(bus.o_busy), 1);
        for (int i = 0; i < 2; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w       = nines[i];
            tick();
        end
        idle_inputs();
        load_weights(twos, 1'b0);
        for (int s = 0; s < 6; s++) apply_stimulus(1, 0, s >= 4, 10);
        drain();

        // Reset in the middle of a load.
        bus.i_w_start = 1'b1;
        tick();
        bus.i_w_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w       = 8'sd1;
            tick();
        end
        idle_inputs();
        do_reset();
        check_output("rst2_o_valid", int'(bus.o_valid), 0);
        check_output("rst2_o_psum", int'(bus.o_psum), 0);
        check_output("rst2_o_busy", int'(bus.o_busy), 1);
        bus.i_w_valid = 1'b1;
        bus.i_w       = 8'sd7;
        for (int i = 0; i < 6; i++) apply_stimulus(5, 0, 1'b0, 0);
        idle_inputs();
        check_output("rst2_idle_busy", int'(bus.o_busy), 1);
        load_weights(ones, 1'b1);
        for (int s = 0; s < 5; s++) apply_stimulus(2, 0, s == 4, 10);
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
